// File: rtl/sfm_tcdm_splitter.sv
// Wide-to-narrow TCDM splitter: fans one DW-bit request into MP word requests and realigns responses.
// Optional performance counters are enabled by defining SFM_TCDM_SPLIT_PERF_EN.

package sfm_pkg;
  localparam int unsigned DATA_W = 128;
endpackage

module sfm_tcdm_splitter
  import sfm_pkg::*;
#(
  parameter int unsigned DW         = DATA_W,
  parameter int unsigned MP         = DW / 32,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // Upstream request: valid/ready style, up_gnt_o is the combinational ready.
  // Address/data must stay stable while up_req_i is high and up_gnt_o is low.
  input  logic                 up_req_i,
  output logic                 up_gnt_o,
  input  logic [31:0]          up_add_i,
  input  logic                 up_wen_i,
  input  logic [DW/8-1:0]      up_be_i,
  input  logic [DW-1:0]        up_data_i,
  output logic                 up_r_valid_o,
  input  logic                 up_r_ready_i,
  output logic [DW-1:0]        up_r_data_o,
  output logic [MP-1:0]        tcdm_req_o,
  input  logic [MP-1:0]        tcdm_gnt_i,
  output logic [MP-1:0][31:0]  tcdm_add_o,
  output logic [MP-1:0]        tcdm_wen_o,
  output logic [MP-1:0][3:0]   tcdm_be_o,
  output logic [MP-1:0][31:0]  tcdm_data_o,
  input  logic [MP-1:0]        tcdm_r_valid_i,
  input  logic [MP-1:0][31:0]  tcdm_r_data_i
`ifdef SFM_TCDM_SPLIT_PERF_EN
  ,
  output logic [31:0]          perf_stall_o,
  output logic [31:0]          perf_skew_o
`endif
);

  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

  logic [MP-1:0] done_q;
  logic [CW-1:0] out_cnt_q;
  logic          issue_en;
  logic          all_done;
  logic          rsp_hs;
  logic [MP-1:0] lane_gnt;
  logic [MP-1:0] lane_push;
  logic [MP-1:0] fifo_nempty;

  logic [31:0]   fifo_mem_q [MP][RESP_DEPTH];
  logic [PW-1:0] wptr_q     [MP];
  logic [PW-1:0] rptr_q     [MP];
  logic [CW-1:0] fcnt_q     [MP];
  // Grants per lane still waiting for their r_valid; responses with no
  // matching grant (e.g. in flight across a reset) are discarded.
  logic [CW-1:0] pend_q     [MP];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign issue_en = (out_cnt_q < CW'(RESP_DEPTH));

  always_comb begin
    tcdm_req_o  = '0;
    tcdm_add_o  = '0;
    tcdm_wen_o  = '0;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    lane_gnt    = '0;
    lane_push   = '0;
    fifo_nempty = '0;
    up_r_data_o = '0;
    for (int ii = 0; ii < int'(MP); ii++) begin
      tcdm_req_o[ii]          = up_req_i & issue_en & ~done_q[ii];
      lane_gnt[ii]            = tcdm_req_o[ii] & tcdm_gnt_i[ii];
      tcdm_add_o[ii]          = up_add_i + 32'(4 * ii);
      tcdm_wen_o[ii]          = up_wen_i;
      tcdm_be_o[ii]           = up_be_i[4*ii +: 4];
      tcdm_data_o[ii]         = up_data_i[32*ii +: 32];
      lane_push[ii]           = tcdm_r_valid_i[ii] & (pend_q[ii] != '0);
      fifo_nempty[ii]         = (fcnt_q[ii] != '0);
      up_r_data_o[32*ii +: 32] = fifo_mem_q[ii][rptr_q[ii]];
    end
  end

  assign all_done     = &(done_q | lane_gnt);
  assign up_gnt_o     = up_req_i & issue_en & all_done;
  assign up_r_valid_o = &fifo_nempty;
  assign rsp_hs       = up_r_valid_o & up_r_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      done_q    <= '0;
      out_cnt_q <= '0;
      for (int ii = 0; ii < int'(MP); ii++) begin
        wptr_q[ii] <= '0;
        rptr_q[ii] <= '0;
        fcnt_q[ii] <= '0;
        pend_q[ii] <= '0;
      end
    end else begin
      done_q <= up_gnt_o ? '0 : (done_q | lane_gnt);

      if (up_gnt_o && !rsp_hs) begin
        out_cnt_q <= out_cnt_q + CW'(1);
      end else if (!up_gnt_o && rsp_hs) begin
        out_cnt_q <= out_cnt_q - CW'(1);
      end

      for (int ii = 0; ii < int'(MP); ii++) begin
        if (lane_push[ii]) begin
          fifo_mem_q[ii][wptr_q[ii]] <= tcdm_r_data_i[ii];
          wptr_q[ii]                 <= ptr_inc(wptr_q[ii]);
        end
        if (rsp_hs) begin
          rptr_q[ii] <= ptr_inc(rptr_q[ii]);
        end

        case ({lane_push[ii], rsp_hs})
          2'b10:   fcnt_q[ii] <= fcnt_q[ii] + CW'(1);
          2'b01:   fcnt_q[ii] <= fcnt_q[ii] - CW'(1);
          default: fcnt_q[ii] <= fcnt_q[ii];
        endcase

        case ({lane_gnt[ii], lane_push[ii]})
          2'b10:   pend_q[ii] <= pend_q[ii] + CW'(1);
          2'b01:   pend_q[ii] <= pend_q[ii] - CW'(1);
          default: pend_q[ii] <= pend_q[ii];
        endcase
      end
    end
  end

`ifdef SFM_TCDM_SPLIT_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_skew_q;

  // Stall: blocked by the outstanding limit. Skew: some lanes granted, others still waiting.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_stall_q <= '0;
      perf_skew_q  <= '0;
    end else begin
      if (up_req_i && !issue_en) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (up_req_i && issue_en && (done_q != '0) && !up_gnt_o) begin
        perf_skew_q <= perf_skew_q + 32'd1;
      end
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_skew_o  = perf_skew_q;
`endif

endmodule

// File: tb/tb_sfm_tcdm_splitter.sv
// Bench for sfm_tcdm_splitter: directed scenarios then randomized traffic against a
// word-memory reference model, with per-lane TCDM slaves that grant and respond with skew.
module tb_sfm_tcdm_splitter;
  localparam int DW = 128;
  localparam int MP = DW / 32;
  localparam int RD = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                up_req_i = 1'b0;
  logic                up_gnt_o;
  logic [31:0]         up_add_i = '0;
  logic                up_wen_i = 1'b1;
  logic [DW/8-1:0]     up_be_i = '0;
  logic [DW-1:0]       up_data_i = '0;
  logic                up_r_valid_o;
  logic                up_r_ready_i = 1'b1;
  logic [DW-1:0]       up_r_data_o;
  logic [MP-1:0]       tcdm_req_o;
  logic [MP-1:0]       tcdm_gnt_i = '0;
  logic [MP-1:0][31:0] tcdm_add_o;
  logic [MP-1:0]       tcdm_wen_o;
  logic [MP-1:0][3:0]  tcdm_be_o;
  logic [MP-1:0][31:0] tcdm_data_o;
  logic [MP-1:0]       tcdm_r_valid_i = '0;
  logic [MP-1:0][31:0] tcdm_r_data_i = '0;
`ifdef SFM_TCDM_SPLIT_PERF_EN
  logic [31:0]         perf_stall_o;
  logic [31:0]         perf_skew_o;
`endif

  sfm_tcdm_splitter #(.DW(DW), .MP(MP), .RESP_DEPTH(RD)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .up_req_i(up_req_i), .up_gnt_o(up_gnt_o), .up_add_i(up_add_i), .up_wen_i(up_wen_i),
    .up_be_i(up_be_i), .up_data_i(up_data_i), .up_r_valid_o(up_r_valid_o),
    .up_r_ready_i(up_r_ready_i), .up_r_data_o(up_r_data_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i)
`ifdef SFM_TCDM_SPLIT_PERF_EN
    , .perf_stall_o(perf_stall_o), .perf_skew_o(perf_skew_o)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard and reference state
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int epoch    = 0;
  int hs_count = 0;
  int n_rsp    = 0;
  int m_stall  = 0;
  int m_skew   = 0;
  bit last_hs  = 0;
  logic [DW-1:0] exp_q[$];
  bit            exp_rd_q[$];
  logic [31:0]   ref_mem [256];
  logic [31:0]   slv_mem [256];
  logic [MP-1:0] got_lanes = '0;
  int            rsp_cnt [MP];

  // Lane slave knobs and in-flight responses
  bit            rand_gnt = 0;
  bit            rand_lat = 0;
  bit            resp_en  = 1;
  logic [MP-1:0] gnt_pat  = '1;
  int            lat [MP];
  logic [31:0]   lq_data [MP][$];
  int            lq_due  [MP][$];
  int            lq_ep   [MP][$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit lanes_busy();
    for (int ii = 0; ii < MP; ii++) if (lq_due[ii].size() > 0) return 1;
    return 0;
  endfunction

  // Driver: slave-side inputs for the current cycle, then settle.
  task automatic cyc_begin();
    for (int ii = 0; ii < MP; ii++) begin
      tcdm_gnt_i[ii] = rand_gnt ? ($urandom_range(0, 2) != 0) : gnt_pat[ii];
      if (resp_en && lq_due[ii].size() > 0 && lq_due[ii][0] <= cyc) begin
        tcdm_r_valid_i[ii] = 1'b1;
        tcdm_r_data_i[ii]  = lq_data[ii][0];
      end else begin
        tcdm_r_valid_i[ii] = 1'b0;
        tcdm_r_data_i[ii]  = $urandom;
      end
    end
    #1;
  endtask

  // Model update and per-cycle comparisons, then advance to the next negedge.
  task automatic cyc_end();
    logic [MP-1:0]       exp_req;
    logic [MP-1:0][31:0] exp_add;
    logic [DW-1:0]       w;
    logic                exp_gnt, issue, exp_rv;
    int                  idx, due, l;
    last_hs = 0;
    if (!rst_n) begin
      exp_q.delete();
      exp_rd_q.delete();
      got_lanes = '0;
      epoch++;
      m_stall = 0;
      m_skew  = 0;
      for (int ii = 0; ii < MP; ii++) rsp_cnt[ii] = 0;
    end else begin
      issue   = (exp_q.size() < RD);
      exp_req = (up_req_i && issue) ? ~got_lanes : '0;
      exp_gnt = up_req_i && issue && (&(got_lanes | tcdm_gnt_i));
      check("tcdm_req", tcdm_req_o, exp_req);
      check("up_gnt", up_gnt_o, exp_gnt);
      if (up_req_i) begin
        for (int ii = 0; ii < MP; ii++) exp_add[ii] = up_add_i + 32'(4 * ii);
        check("tcdm_add", tcdm_add_o, exp_add);
        check("tcdm_data", tcdm_data_o, up_data_i);
        check("tcdm_be", tcdm_be_o, up_be_i);
        check("tcdm_wen", tcdm_wen_o, {MP{up_wen_i}});
      end
      exp_rv = 1'b1;
      for (int ii = 0; ii < MP; ii++) if (rsp_cnt[ii] == 0) exp_rv = 1'b0;
      check("up_r_valid", up_r_valid_o, exp_rv);

      if (up_req_i && !issue) m_stall++;
      else if (up_req_i && got_lanes != '0 && !exp_gnt) m_skew++;

      for (int ii = 0; ii < MP; ii++) begin
        if (tcdm_req_o[ii] && tcdm_gnt_i[ii]) begin
          idx = int'(tcdm_add_o[ii][9:2]);
          l   = rand_lat ? int'($urandom_range(1, 4)) : lat[ii];
          due = cyc + l;
          if (lq_due[ii].size() > 0 && due <= lq_due[ii][$]) due = lq_due[ii][$] + 1;
          if (tcdm_wen_o[ii]) begin
            lq_data[ii].push_back(slv_mem[idx]);
          end else begin
            for (int b = 0; b < 4; b++)
              if (tcdm_be_o[ii][b]) slv_mem[idx][8*b +: 8] = tcdm_data_o[ii][8*b +: 8];
            lq_data[ii].push_back($urandom);
          end
          lq_due[ii].push_back(due);
          lq_ep[ii].push_back(epoch);
          got_lanes[ii] = 1'b1;
        end
      end

      if (exp_gnt) begin
        idx = int'(up_add_i[9:2]);
        w   = '0;
        for (int ii = 0; ii < MP; ii++) begin
          if (up_wen_i) begin
            w[32*ii +: 32] = ref_mem[idx + ii];
          end else begin
            for (int b = 0; b < 4; b++)
              if (up_be_i[4*ii + b]) ref_mem[idx + ii][8*b +: 8] = up_data_i[32*ii + 8*b +: 8];
          end
        end
        exp_q.push_back(w);
        exp_rd_q.push_back(up_wen_i);
        got_lanes = '0;
        hs_count++;
        last_hs = 1;
      end

      if (exp_rv && up_r_ready_i && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        if (exp_rd_q.pop_front()) check("rsp_data", up_r_data_o, w);
        n_rsp++;
        for (int ii = 0; ii < MP; ii++) if (rsp_cnt[ii] > 0) rsp_cnt[ii]--;
      end
    end

    for (int ii = 0; ii < MP; ii++) begin
      if (tcdm_r_valid_i[ii]) begin
        if (rst_n && lq_ep[ii][0] == epoch) rsp_cnt[ii]++;
        void'(lq_data[ii].pop_front());
        void'(lq_due[ii].pop_front());
        void'(lq_ep[ii].pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    cyc_begin();
    cyc_end();
  endtask

  task automatic new_req(input logic wen, input logic [31:0] add, input logic [DW/8-1:0] be);
    up_req_i = 1'b1;
    up_wen_i = wen;
    up_add_i = add;
    up_be_i  = be;
    for (int ii = 0; ii < MP; ii++) up_data_i[32*ii +: 32] = $urandom;
  endtask

  task automatic drain(input int budget);
    int k;
    up_r_ready_i = 1'b1;
    rand_gnt     = 0;
    gnt_pat      = '1;
    resp_en      = 1;
    k = 0;
    while (k < budget && (up_req_i || exp_q.size() > 0 || lanes_busy())) begin
      step();
      if (last_hs) up_req_i = 1'b0;
      k++;
    end
    check("drain_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    int h0, r0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    for (int ii = 0; ii < MP; ii++) begin
      lat[ii]     = 1;
      rsp_cnt[ii] = 0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;

    // Reset state
    cyc_begin();
    check("rst_up_gnt", up_gnt_o, 0);
    check("rst_up_r_valid", up_r_valid_o, 0);
    check("rst_tcdm_req", tcdm_req_o, 0);
    cyc_end();

    // All lanes granted at once, read at 0x100
    new_req(1'b1, 32'h100, '1);
    cyc_begin();
    check("t1_add0", tcdm_add_o[0], 32'h100);
    check("t1_add3", tcdm_add_o[3], 32'h10C);
    check("t1_gnt_same_cycle", up_gnt_o, 1);
    cyc_end();
    up_req_i = 1'b0;
    cyc_begin();
    check("t1_rv_during_lane_rvalid", up_r_valid_o, 0);
    cyc_end();
    cyc_begin();
    check("t1_rv_next_cycle", up_r_valid_o, 1);
    cyc_end();
    drain(20);

    // Lane 2 grant delayed by three cycles
    h0 = hs_count;
    gnt_pat = 4'b1011;
    new_req(1'b1, 32'h040, '1);
    cyc_begin();
    check("t2_req_c0", tcdm_req_o, 4'b1111);
    check("t2_gnt_c0", up_gnt_o, 0);
    cyc_end();
    for (int c = 1; c < 3; c++) begin
      cyc_begin();
      check("t2_req_held", tcdm_req_o, 4'b0100);
      check("t2_gnt_low", up_gnt_o, 0);
      cyc_end();
    end
    gnt_pat = '1;
    cyc_begin();
    check("t2_req_c3", tcdm_req_o, 4'b0100);
    check("t2_gnt_c3", up_gnt_o, 1);
    cyc_end();
    up_req_i = 1'b0;
    drain(20);
    check("t2_single_handshake", hs_count - h0, 1);

    // Skewed responses: lane0 at t, lane3 at t+4
    lat[0] = 1; lat[1] = 2; lat[2] = 3; lat[3] = 5;
    new_req(1'b1, 32'h080, '1);
    step();
    up_req_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc_begin();
      check("t3_rv_low_while_skewed", up_r_valid_o, 0);
      cyc_end();
    end
    cyc_begin();
    check("t3_rv_at_t_plus_5", up_r_valid_o, 1);
    cyc_end();
    drain(20);
    for (int ii = 0; ii < MP; ii++) lat[ii] = 1;

    // Outstanding limit under backpressure
    up_r_ready_i = 1'b0;
    new_req(1'b1, 32'h0C0, '1);
    step();
    new_req(1'b1, 32'h0D0, '1);
    step();
    new_req(1'b1, 32'h0E0, '1);
    cyc_begin();
    check("t4_third_req_blocked", tcdm_req_o, 0);
    check("t4_third_gnt_blocked", up_gnt_o, 0);
    cyc_end();
    step();
    step();
    up_r_ready_i = 1'b1;
    cyc_begin();
    check("t4_blocked_during_pop", tcdm_req_o, 0);
    cyc_end();
    up_r_ready_i = 1'b0;
    cyc_begin();
    check("t4_reenabled_req", tcdm_req_o, 4'b1111);
    check("t4_reenabled_gnt", up_gnt_o, 1);
    cyc_end();
    up_req_i = 1'b0;
    drain(30);

    // Byte-enabled write, then read back
    h0 = hs_count;
    r0 = n_rsp;
    new_req(1'b0, 32'h200, 16'h0F0F);
    cyc_begin();
    check("t5_be_lanes", tcdm_be_o, 16'h0F0F);
    check("t5_wen", tcdm_wen_o, 4'b0000);
    cyc_end();
    up_req_i = 1'b0;
    drain(20);
    check("t5_one_response", n_rsp - r0, 1);
    new_req(1'b1, 32'h200, '1);
    drain(20);

    // Reset with two reads outstanding and responses still in flight
    resp_en      = 0;
    up_r_ready_i = 1'b0;
    new_req(1'b1, 32'h300, '1);
    step();
    new_req(1'b1, 32'h310, '1);
    step();
    up_req_i = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n   = 1'b1;
    resp_en = 1;
    cyc_begin();
    check("t6_rv_after_reset", up_r_valid_o, 0);
    check("t6_req_after_reset", tcdm_req_o, 0);
    cyc_end();
    for (int k = 0; k < 6; k++) begin
      cyc_begin();
      check("t6_stale_dropped", up_r_valid_o, 0);
      cyc_end();
    end
    new_req(1'b1, 32'h300, '1);
    drain(20);

    // Randomized traffic
    rand_gnt = 1;
    rand_lat = 1;
    for (int k = 0; k < 800; k++) begin
      if (!up_req_i && $urandom_range(0, 2) != 0)
        new_req(logic'($urandom_range(0, 1)), 32'($urandom_range(0, 252) * 4), DW'($urandom) );
      up_r_ready_i = ($urandom_range(0, 3) != 0);
      step();
      if (last_hs) up_req_i = 1'b0;
    end
    drain(200);

`ifdef SFM_TCDM_SPLIT_PERF_EN
    check("perf_stall", perf_stall_o, 32'(m_stall));
    check("perf_skew", perf_skew_o, 32'(m_skew));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
